// File: rtl/operand_fetch.sv
// Operand-fetch / issue stage: regfile read, writeback bypass,
// busy scoreboard with RAW/WAW stall, valid/ready register toward EX.
module operand_fetch #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int PC_W   = 32
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_flush,
  input  logic              i_id_valid,
  output logic              o_id_ready,
  input  logic [PC_W-1:0]   i_id_pc,
  input  logic [ADDR_W-1:0] i_id_rs1_addr,
  input  logic [ADDR_W-1:0] i_id_rs2_addr,
  input  logic [ADDR_W-1:0] i_id_rd_addr,
  input  logic              i_id_rd_wren,
  output logic [ADDR_W-1:0] o_rs1_addr,
  output logic [ADDR_W-1:0] o_rs2_addr,
  input  logic [DATA_W-1:0] i_rs1_data,
  input  logic [DATA_W-1:0] i_rs2_data,
  input  logic [ADDR_W-1:0] i_wb_rd_addr,
  input  logic [DATA_W-1:0] i_wb_rd_data,
  input  logic              i_wb_rd_wren,
  output logic              o_ex_valid,
  input  logic              i_ex_ready,
  output logic [PC_W-1:0]   o_ex_pc,
  output logic [DATA_W-1:0] o_ex_rs1_data,
  output logic [DATA_W-1:0] o_ex_rs2_data,
  output logic [ADDR_W-1:0] o_ex_rd_addr,
  output logic              o_ex_rd_wren
);

  localparam int NREG = 2**ADDR_W;

  logic [NREG-1:0]   r_busy;
  logic [NREG-1:0]   w_busy_nxt;
  logic              r_ex_valid;
  logic [PC_W-1:0]   r_ex_pc;
  logic [DATA_W-1:0] r_ex_rs1;
  logic [DATA_W-1:0] r_ex_rs2;
  logic [ADDR_W-1:0] r_ex_rd;
  logic              r_ex_wren;

  logic              w_hit_rs1;
  logic              w_hit_rs2;
  logic              w_hit_rd;
  logic              w_haz_rs1;
  logic              w_haz_rs2;
  logic              w_haz_rd;
  logic              w_stall;
  logic              w_accept;
  logic [DATA_W-1:0] w_rs1_op;
  logic [DATA_W-1:0] w_rs2_op;

  assign o_rs1_addr = i_id_rs1_addr;
  assign o_rs2_addr = i_id_rs2_addr;

  assign w_hit_rs1 = i_wb_rd_wren
                  && (i_wb_rd_addr == i_id_rs1_addr)
                  && (i_id_rs1_addr != '0);
  assign w_hit_rs2 = i_wb_rd_wren
                  && (i_wb_rd_addr == i_id_rs2_addr)
                  && (i_id_rs2_addr != '0);
  assign w_hit_rd  = i_wb_rd_wren
                  && (i_wb_rd_addr == i_id_rd_addr);

  assign w_rs1_op = (i_id_rs1_addr == '0) ? '0
                  : w_hit_rs1 ? i_wb_rd_data
                  : i_rs1_data;
  assign w_rs2_op = (i_id_rs2_addr == '0) ? '0
                  : w_hit_rs2 ? i_wb_rd_data
                  : i_rs2_data;

  // A writeback landing this cycle resolves the hazard it would cause.
  assign w_haz_rs1 = (i_id_rs1_addr != '0)
                  && r_busy[i_id_rs1_addr]
                  && !w_hit_rs1;
  assign w_haz_rs2 = (i_id_rs2_addr != '0)
                  && r_busy[i_id_rs2_addr]
                  && !w_hit_rs2;
  assign w_haz_rd  = i_id_rd_wren
                  && (i_id_rd_addr != '0)
                  && r_busy[i_id_rd_addr]
                  && !w_hit_rd;
  assign w_stall   = w_haz_rs1 || w_haz_rs2 || w_haz_rd;

  assign o_id_ready = !i_flush && !w_stall
                   && (!r_ex_valid || i_ex_ready);
  assign w_accept   = i_id_valid && o_id_ready;

  assign o_ex_valid    = r_ex_valid;
  assign o_ex_pc       = r_ex_pc;
  assign o_ex_rs1_data = r_ex_rs1;
  assign o_ex_rs2_data = r_ex_rs2;
  assign o_ex_rd_addr  = r_ex_rd;
  assign o_ex_rd_wren  = r_ex_wren;

  // Scoreboard next state: clears first, then set, so set wins.
  always_comb begin
    w_busy_nxt = r_busy;
    if (i_wb_rd_wren)
      w_busy_nxt[i_wb_rd_addr] = 1'b0;
    if (i_flush && r_ex_valid && r_ex_wren)
      w_busy_nxt[r_ex_rd] = 1'b0;
    if (w_accept && i_id_rd_wren)
      w_busy_nxt[i_id_rd_addr] = 1'b1;
    w_busy_nxt[0] = 1'b0;
  end

  // Scoreboard register.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) r_busy <= '0;
    else            r_busy <= w_busy_nxt;
  end

  // EX output register: flush, then load, then drain.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_ex_valid <= 1'b0;
      r_ex_pc    <= '0;
      r_ex_rs1   <= '0;
      r_ex_rs2   <= '0;
      r_ex_rd    <= '0;
      r_ex_wren  <= 1'b0;
    end else if (i_flush) begin
      r_ex_valid <= 1'b0;
    end else if (w_accept) begin
      r_ex_valid <= 1'b1;
      r_ex_pc    <= i_id_pc;
      r_ex_rs1   <= w_rs1_op;
      r_ex_rs2   <= w_rs2_op;
      r_ex_rd    <= i_id_rd_addr;
      r_ex_wren  <= i_id_rd_wren;
    end else if (i_ex_ready) begin
      r_ex_valid <= 1'b0;
    end
  end

endmodule

// File: doc/operand_fetch.md
Name: operand_fetch

Overview:
- Issue/operand-fetch stage between decode and execute.
- Drives the register file read addresses and receives its combinational read data.
- Bypasses same-cycle writeback data, so a register written this cycle reads with its new value.
- Keeps a 32-entry busy scoreboard, stalls on RAW/WAW hazards, and registers operands into a valid/ready handshake toward execute.

Parameters:
- DATA_W, 32, operand/register data width.
- ADDR_W, 5, register address width (2**ADDR_W registers; x0 hardwired zero).
- PC_W, 32, program-counter width carried alongside the instruction.

Ports:
- i_clk  input  1  single clock; all state on rising edge.
- i_reset_n  input  1  asynchronous, active-low reset.
- i_flush  input  1  synchronous flush; drops the held EX entry.
- i_id_valid  input  1  decode has an instruction.
- o_id_ready  output  1  stage accepts the instruction this cycle.
- i_id_pc  input  PC_W  instruction PC.
- i_id_rs1_addr  input  ADDR_W  source 1 register.
- i_id_rs2_addr  input  ADDR_W  source 2 register.
- i_id_rd_addr  input  ADDR_W  destination register.
- i_id_rd_wren  input  1  instruction writes rd.
- o_rs1_addr  output  ADDR_W  regfile read address 1 (= i_id_rs1_addr, combinational).
- o_rs2_addr  output  ADDR_W  regfile read address 2 (= i_id_rs2_addr, combinational).
- i_rs1_data  input  DATA_W  regfile read data 1.
- i_rs2_data  input  DATA_W  regfile read data 2.
- i_wb_rd_addr  input  ADDR_W  writeback destination (same signals that drive the regfile write port).
- i_wb_rd_data  input  DATA_W  writeback data.
- i_wb_rd_wren  input  1  writeback valid.
- o_ex_valid  output  1  EX output register holds an instruction.
- i_ex_ready  input  1  execute consumes the entry.
- o_ex_pc  output  PC_W  registered PC.
- o_ex_rs1_data  output  DATA_W  registered operand 1.
- o_ex_rs2_data  output  DATA_W  registered operand 2.
- o_ex_rd_addr  output  ADDR_W  registered rd.
- o_ex_rd_wren  output  1  registered rd write enable.

Behaviour:
- Reset (i_reset_n=0, asynchronous):
  - busy[31:0] = 0; o_ex_valid = 0.
  - All o_ex_* data/address fields = 0.
  - Reset mid-stall discards everything; no writeback is expected afterwards.
- wb_hit_rsN = i_wb_rd_wren && i_wb_rd_addr == rsN && rsN != 0.
- Operand select: rsN == 0 -> 0; else wb_hit_rsN -> i_wb_rd_data; else i_rsN_data.
- Hazards:
  - hazard_rsN = rsN != 0 && busy[rsN] && !wb_hit_rsN.
  - hazard_rd = i_id_rd_wren && rd != 0 && busy[rd] && !(i_wb_rd_wren && i_wb_rd_addr == rd).
  - stall = hazard_rs1 || hazard_rs2 || hazard_rd.
- o_id_ready = !i_flush && !stall && (!o_ex_valid || i_ex_ready). This is combinational; no registered ready.
- accept = i_id_valid && o_id_ready. Decode holds all i_id_* stable while i_id_valid && !o_id_ready.
- EX register, each cycle in priority order:
  - i_flush: o_ex_valid <= 0.
  - accept: load all fields; o_ex_valid <= 1.
  - i_ex_ready: o_ex_valid <= 0.
  - Otherwise hold; data fields are not cleared on drain.
- Latency: accepted in cycle N, visible on o_ex_* in cycle N+1. Back-to-back independent instructions sustain 1 per cycle.
- Scoreboard update per cycle, applied in order:
  - (a) clear busy[i_wb_rd_addr] if i_wb_rd_wren && addr != 0.
  - (b) if i_flush && o_ex_valid && o_ex_rd_wren, clear busy[o_ex_rd_addr].
  - (c) set busy[i_id_rd_addr] if accept && i_id_rd_wren && rd != 0.
  - Set wins over clear on the same index. busy[0] is always 0.
- A writeback to a non-busy register only updates the bypass; it has no scoreboard effect and raises no error.
- Flush does not clear busy bits of instructions already past EX; their writebacks still clear them.

Test Plan:
- Reset: assert i_reset_n=0 mid-transfer -> o_ex_valid=0, busy=0 immediately. First accept after release presents operands next cycle.
- Independent stream: x1=5, x2=7 in regfile; issue add x3,x1,x2 then add x4,x1,x1 with i_ex_ready=1 -> both accepted on consecutive cycles. o_ex_rs1/rs2 = 5/7, then 5/5.
- RAW stall plus bypass: issue rd=x3, then rs1=x3 -> o_id_ready=0 until the writeback cycle (x3=0x1234). In that cycle ready=1 and o_ex_rs1_data=0x1234 next cycle, not the stale regfile value.
- x0 rules: rd=x0 write enabled, then rs1=x0 -> no stall, operand 0. A writeback to x0 with data 0xFFFF_FFFF is not bypassed.
- Backpressure: i_ex_ready=0 for 3 cycles with o_ex_valid=1 -> o_id_ready=0 and o_ex_* hold. Ready returns -> the next instruction loads the same cycle.
- Flush: held EX entry rd=x5, i_flush=1 -> o_ex_valid=0, busy[5]=0. A following rs1=x5 instruction issues without stall.
